lift_call_scheduler: RTL and testbench

LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

---
 rtl/lift_call_scheduler_pkg.sv | 32 +++
 rtl/lift_call_scheduler_rr_pick.sv | 31 +++
 rtl/lift_call_scheduler.sv | 55 +++++
 tb/tb_lift_call_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lift_call_scheduler_pkg.sv
// Shared lift definitions: call count, call-code encodings and the
// pending-bit-index to call-code mapping used by scheduler and lift FSM.
package lift_call_scheduler_pkg;

  localparam int NUM_CALLS = 6;
  localparam int CODE_W    = 3;
  localparam int IDX_W     = 3;

  typedef logic [CODE_W-1:0] call_code_t;

  localparam call_code_t CODE_NONE = 3'b000;
  localparam call_code_t CODE_1U   = 3'b001;
  localparam call_code_t CODE_2U   = 3'b010;
  localparam call_code_t CODE_3U   = 3'b011;
  localparam call_code_t CODE_2D   = 3'b110;
  localparam call_code_t CODE_3D   = 3'b111;
  localparam call_code_t CODE_4D   = 3'b100;

  // Bit order of the pending/button vectors: 1U, 2U, 3U, 2D, 3D, 4D.
  function automatic call_code_t idx_to_code(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return CODE_1U;
      3'd1:    return CODE_2U;
      3'd2:    return CODE_3U;
      3'd3:    return CODE_2D;
      3'd4:    return CODE_3D;
      3'd5:    return CODE_4D;
      default: return CODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lift_call_scheduler_rr_pick.sv
// Rotating first-set search over the pending calls: the first set bit at or
// after start, wrapping modulo NUM_CALLS.
module lift_rr_pick
  import lift_call_scheduler_pkg::*;
(
  input  logic [NUM_CALLS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic                 vld,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   pos;

  always_comb begin
    base = (start > 3'd5) ? 3'd0 : start;
    vld  = 1'b0;
    idx  = '0;
    pos  = '0;
    // Scan farthest offset first so the nearest set bit is the last to write.
    for (int off = NUM_CALLS - 1; off >= 0; off--) begin
      pos = {1'b0, base} + 4'(off);
      if (pos >= 4'd6) pos = pos - 4'd6;
      if (req[pos[IDX_W-1:0]]) begin
        vld = 1'b1;
        idx = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/lift_call_scheduler.sv
// Hall-call scheduler: latches button presses, offers one call at a time to
// the lift FSM in round-robin order and counts the calls it hands over.
module lift_call_scheduler
  import lift_call_scheduler_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CALLS-1:0] call_btn,
  input  logic                 fsm_done,
  output logic                 q_empty,
  output logic [CODE_W-1:0]    call_code,
  output logic [NUM_CALLS-1:0] pending,
  output logic [CNT_W-1:0]     served_cnt
);

  logic [IDX_W-1:0]     rr_ptr;
  logic                 holdoff;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic                 issue;
  logic [NUM_CALLS-1:0] clr_mask;

  lift_rr_pick u_pick (
    .req   (pending),
    .start (rr_ptr),
    .vld   (pick_vld),
    .idx   (pick_idx)
  );

  // Offer is a function of registered state only; fsm_done just accepts it.
  assign q_empty   = !pick_vld || holdoff;
  assign call_code = q_empty ? CODE_NONE : idx_to_code(pick_idx);
  assign issue     = fsm_done && !q_empty;
  assign clr_mask  = issue ? (6'(1) << pick_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      rr_ptr     <= '0;
      holdoff    <= 1'b0;
      served_cnt <= '0;
    end else begin
      holdoff <= issue;
      // A press of the call being issued re-arms it: set wins over clear.
      pending <= (pending & ~clr_mask) | call_btn;
      if (issue) begin
        rr_ptr     <= (pick_idx == 3'd5) ? 3'd0 : pick_idx + 3'd1;
        served_cnt <= served_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Bench for lift_call_scheduler: directed scenarios plus randomized traffic
// against a behavioural call-queue model.
module tb_lift_call_scheduler;
  import lift_call_scheduler_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       call_btn = '0;
  logic             fsm_done = 1'b0;
  logic             q_empty;
  logic [2:0]       call_code;
  logic [5:0]       pending;
  logic [CNT_W-1:0] served_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lift_call_scheduler #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .call_btn   (call_btn),
    .fsm_done   (fsm_done),
    .q_empty    (q_empty),
    .call_code  (call_code),
    .pending    (pending),
    .served_cnt (served_cnt)
  );

  // Reference model: set of pending calls, rotation start, holdoff flag, count.
  bit m_pend[6];
  int m_ptr;
  bit m_hold;
  int m_cnt;
  int code_tab[6] = '{1, 2, 3, 6, 7, 4};

  function automatic int m_pick();
    int k;
    for (int off = 0; off < 6; off++) begin
      k = (m_ptr + off) % 6;
      if (m_pend[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit m_empty();
    return m_hold || (m_pick() < 0);
  endfunction

  function automatic logic [2:0] m_code();
    if (m_empty()) return 3'b000;
    return 3'(code_tab[m_pick()]);
  endfunction

  function automatic logic [5:0] m_vec();
    logic [5:0] v;
    for (int i = 0; i < 6; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [5:0] b, input logic d);
    int k;
    rst = r; call_btn = b; fsm_done = d;
    k = (d && !m_empty()) ? m_pick() : -1;
    if (r) begin
      for (int i = 0; i < 6; i++) m_pend[i] = 1'b0;
      m_ptr = 0; m_hold = 1'b0; m_cnt = 0;
    end else begin
      if (k >= 0) begin
        m_pend[k] = 1'b0;
        m_ptr = (k + 1) % 6;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      m_hold = (k >= 0);
      for (int i = 0; i < 6; i++) if (b[i]) m_pend[i] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 6'b111111, 1'b1);
    cyc(1'b1, 6'b000000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 6'b000000, 1'b0);
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL reset_q_empty got %0b want 1", q_empty); end
    n_tests++; if (call_code !== 3'b000) begin n_fail++; $display("FAIL reset_call_code got %03b want 000", call_code); end
    n_tests++; if (pending !== 6'b000000) begin n_fail++; $display("FAIL reset_pending got %06b want 000000", pending); end
    n_tests++; if (served_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_served got %0d want 0", served_cnt); end
  endtask

  task automatic test_single_call();
    cyc(1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 6'b000100, 1'b1);
    n_tests++; if (pending !== 6'b000100) begin n_fail++; $display("FAIL single_pending got %06b want 000100", pending); end
    n_tests++; if (call_code !== 3'b011) begin n_fail++; $display("FAIL single_code got %03b want 011", call_code); end
    n_tests++; if (q_empty !== 1'b0) begin n_fail++; $display("FAIL single_offer got %0b want 0", q_empty); end
    cyc(1'b0, 6'b000000, 1'b1);
    n_tests++; if (pending !== 6'b000000) begin n_fail++; $display("FAIL single_cleared got %06b want 000000", pending); end
    n_tests++; if (served_cnt !== 8'd1) begin n_fail++; $display("FAIL single_served got %0d want 1", served_cnt); end
    n_tests++; if (q_empty !== 1'b1 || call_code !== 3'b000) begin n_fail++; $display("FAIL single_holdoff got q_empty=%0b code=%03b want 1/000", q_empty, call_code); end
    cyc(1'b0, 6'b000000, 1'b1);
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL single_after got %0b want 1", q_empty); end
  endtask

  task automatic test_three_calls();
    logic [2:0] seen[$];
    bit         prev_offer;
    bit         back_to_back;
    cyc(1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 6'b101001, 1'b1);
    prev_offer = 1'b0;
    back_to_back = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (q_empty === 1'b0) begin
        seen.push_back(call_code);
        if (prev_offer) back_to_back = 1'b1;
      end
      prev_offer = (q_empty === 1'b0);
      cyc(1'b0, 6'b000000, 1'b1);
    end
    n_tests++; if (seen.size() != 3) begin n_fail++; $display("FAIL three_count got %0d want 3", seen.size()); end
    if (seen.size() == 3) begin
      n_tests++; if (seen[0] !== 3'b001) begin n_fail++; $display("FAIL three_first got %03b want 001", seen[0]); end
      n_tests++; if (seen[1] !== 3'b110) begin n_fail++; $display("FAIL three_second got %03b want 110", seen[1]); end
      n_tests++; if (seen[2] !== 3'b100) begin n_fail++; $display("FAIL three_third got %03b want 100", seen[2]); end
    end
    n_tests++; if (back_to_back) begin n_fail++; $display("FAIL three_gap got back-to-back offers want holdoff gap"); end
    n_tests++; if (dut.rr_ptr !== 3'd0) begin n_fail++; $display("FAIL three_rr_ptr got %0d want 0", dut.rr_ptr); end
    n_tests++; if (served_cnt !== 8'd3) begin n_fail++; $display("FAIL three_served got %0d want 3", served_cnt); end
  endtask

  task automatic test_hold_button();
    cyc(1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 6'b000010, 1'b1);
    cyc(1'b0, 6'b000010, 1'b1);
    n_tests++; if (pending !== 6'b000010) begin n_fail++; $display("FAIL hold_pending got %06b want 000010", pending); end
    n_tests++; if (served_cnt !== 8'd1) begin n_fail++; $display("FAIL hold_served got %0d want 1", served_cnt); end
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL hold_holdoff got %0b want 1", q_empty); end
    n_tests++; if (dut.rr_ptr !== 3'd2) begin n_fail++; $display("FAIL hold_rr_ptr got %0d want 2", dut.rr_ptr); end
    cyc(1'b0, 6'b000000, 1'b0);
    n_tests++; if (q_empty !== 1'b0 || call_code !== 3'b010) begin n_fail++; $display("FAIL hold_reoffer got q_empty=%0b code=%03b want 0/010", q_empty, call_code); end
  endtask

  task automatic test_no_done_then_reset();
    cyc(1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 6'b111111, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 6'b000000, 1'b0);
    n_tests++; if (served_cnt !== 8'd0) begin n_fail++; $display("FAIL nodone_served got %0d want 0", served_cnt); end
    n_tests++; if (pending !== 6'b111111) begin n_fail++; $display("FAIL nodone_pending got %06b want 111111", pending); end
    n_tests++; if (q_empty !== 1'b0 || call_code !== 3'b001) begin n_fail++; $display("FAIL nodone_offer got q_empty=%0b code=%03b want 0/001", q_empty, call_code); end
    cyc(1'b1, 6'b010101, 1'b1);
    n_tests++; if (pending !== 6'b000000) begin n_fail++; $display("FAIL rstissue_pending got %06b want 000000", pending); end
    n_tests++; if (served_cnt !== 8'd0) begin n_fail++; $display("FAIL rstissue_served got %0d want 0", served_cnt); end
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL rstissue_q_empty got %0b want 1", q_empty); end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 6'b000001, 1'b1);
    for (int i = 0; i < 509; i++) cyc(1'b0, 6'b000001, 1'b1);
    n_tests++; if (served_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", served_cnt); end
    cyc(1'b0, 6'b000001, 1'b1);
    cyc(1'b0, 6'b000001, 1'b1);
    n_tests++; if (served_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_256 got %0d want 0", served_cnt); end
  endtask

  task automatic test_random();
    logic [5:0] b;
    logic       d;
    logic       r;
    cyc(1'b1, 6'b000000, 1'b0);
    for (int i = 0; i < 600; i++) begin
      b = 6'($urandom) & 6'($urandom) & 6'($urandom);
      d = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 79) == 0);
      cyc(r, b, d);
      n_tests++; if (q_empty !== m_empty()) begin n_fail++; $display("FAIL rand_q_empty cyc %0d got %0b want %0b", i, q_empty, m_empty()); end
      n_tests++; if (call_code !== m_code()) begin n_fail++; $display("FAIL rand_code cyc %0d got %03b want %03b", i, call_code, m_code()); end
      n_tests++; if (pending !== m_vec()) begin n_fail++; $display("FAIL rand_pending cyc %0d got %06b want %06b", i, pending, m_vec()); end
      n_tests++; if (served_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rand_served cyc %0d got %0d want %0d", i, served_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_three_calls();
    test_hold_button();
    test_no_done_then_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
